// File: rtl/mem_stats_engine.sv
// Small element store with a sequential scan that reports sum, max and min
// (with lowest-index tie-breaking) once per start request.
module mem_stats_engine #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 14,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int SUM_W  = DATA_W + ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              wr_err,
   output logic [SUM_W-1:0]  sum,
   output logic [DATA_W-1:0] max_val,
   output logic [ADDR_W-1:0] max_idx,
   output logic [DATA_W-1:0] min_val,
   output logic [ADDR_W-1:0] min_idx
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [SUM_W-1:0]  acc_sum_q, acc_sum_d;
   logic [DATA_W-1:0] acc_max_q, acc_max_d;
   logic [ADDR_W-1:0] acc_maxi_q, acc_maxi_d;
   logic [DATA_W-1:0] acc_min_q, acc_min_d;
   logic [ADDR_W-1:0] acc_mini_q, acc_mini_d;

   logic [SUM_W-1:0]  sum_q;
   logic [DATA_W-1:0] max_val_q, min_val_q;
   logic [ADDR_W-1:0] max_idx_q, min_idx_q;
   logic              wr_err_q;

   logic              wr_req_bad_s;
   logic              wr_ok_s;
   logic              load_s;
   logic [DATA_W-1:0] elem_s;
   logic [SUM_W-1:0]  scan_sum_s;
   logic [DATA_W-1:0] scan_max_s, scan_min_s;
   logic [ADDR_W-1:0] scan_maxi_s, scan_mini_s;

   // Write acceptance: blocked only while scanning or when out of range.
   always_comb begin
      wr_req_bad_s = 1'b0;
      wr_ok_s      = 1'b0;
      if (wr_en) begin
         wr_req_bad_s = (state_q == ST_SCAN) || ({1'b0, wr_addr} >= DEPTH_V);
         wr_ok_s      = !wr_req_bad_s;
      end else begin
         wr_req_bad_s = 1'b0;
         wr_ok_s      = 1'b0;
      end
   end

   // Element storage, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_ok_s) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign elem_s = mem_q[idx_q];

   // One-element accumulate step; element 0 seeds max and min.
   always_comb begin
      scan_sum_s  = acc_sum_q + {{ADDR_W{1'b0}}, elem_s};
      scan_max_s  = acc_max_q;
      scan_maxi_s = acc_maxi_q;
      scan_min_s  = acc_min_q;
      scan_mini_s = acc_mini_q;
      if (idx_q == {ADDR_W{1'b0}}) begin
         scan_sum_s  = {{ADDR_W{1'b0}}, elem_s};
         scan_max_s  = elem_s;
         scan_maxi_s = idx_q;
         scan_min_s  = elem_s;
         scan_mini_s = idx_q;
      end else begin
         if (elem_s > acc_max_q) begin
            scan_max_s  = elem_s;
            scan_maxi_s = idx_q;
         end else begin
            scan_max_s  = acc_max_q;
            scan_maxi_s = acc_maxi_q;
         end
         if (elem_s < acc_min_q) begin
            scan_min_s  = elem_s;
            scan_mini_s = idx_q;
         end else begin
            scan_min_s  = acc_min_q;
            scan_mini_s = acc_mini_q;
         end
      end
   end

   // Scan sequencer next-state logic.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_sum_d  = acc_sum_q;
      acc_max_d  = acc_max_q;
      acc_maxi_d = acc_maxi_q;
      acc_min_d  = acc_min_q;
      acc_mini_d = acc_mini_q;
      load_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SCAN;
               idx_d      = {ADDR_W{1'b0}};
               acc_sum_d  = {SUM_W{1'b0}};
               acc_max_d  = {DATA_W{1'b0}};
               acc_maxi_d = {ADDR_W{1'b0}};
               acc_min_d  = {DATA_W{1'b0}};
               acc_mini_d = {ADDR_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            acc_sum_d  = scan_sum_s;
            acc_max_d  = scan_max_s;
            acc_maxi_d = scan_maxi_s;
            acc_min_d  = scan_min_s;
            acc_mini_d = scan_mini_s;
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               load_s  = 1'b1;
            end else begin
               idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer and accumulator registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= {ADDR_W{1'b0}};
         acc_sum_q  <= {SUM_W{1'b0}};
         acc_max_q  <= {DATA_W{1'b0}};
         acc_maxi_q <= {ADDR_W{1'b0}};
         acc_min_q  <= {DATA_W{1'b0}};
         acc_mini_q <= {ADDR_W{1'b0}};
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_sum_q  <= acc_sum_d;
         acc_max_q  <= acc_max_d;
         acc_maxi_q <= acc_maxi_d;
         acc_min_q  <= acc_min_d;
         acc_mini_q <= acc_mini_d;
      end
   end

   // Result registers load only on entry to DONE; wr_err is a one-cycle flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q     <= {SUM_W{1'b0}};
         max_val_q <= {DATA_W{1'b0}};
         max_idx_q <= {ADDR_W{1'b0}};
         min_val_q <= {DATA_W{1'b0}};
         min_idx_q <= {ADDR_W{1'b0}};
         wr_err_q  <= 1'b0;
      end else begin
         wr_err_q <= wr_req_bad_s;
         if (load_s) begin
            sum_q     <= scan_sum_s;
            max_val_q <= scan_max_s;
            max_idx_q <= scan_maxi_s;
            min_val_q <= scan_min_s;
            min_idx_q <= scan_mini_s;
         end
      end
   end

   assign busy    = (state_q == ST_SCAN);
   assign done    = (state_q == ST_DONE);
   assign wr_err  = wr_err_q;
   assign sum     = sum_q;
   assign max_val = max_val_q;
   assign max_idx = max_idx_q;
   assign min_val = min_val_q;
   assign min_idx = min_idx_q;

endmodule

// File: tb/tb_mem_stats_engine.sv
// Scoreboard bench for mem_stats_engine: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_mem_stats_engine;

   typedef struct packed {
      logic [11:0] sum;
      logic [7:0]  maxv;
      logic [3:0]  maxi;
      logic [7:0]  minv;
      logic [3:0]  mini;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        start;
   logic        busy, done, wr_err;
   logic [11:0] sum;
   logic [7:0]  max_val, min_val;
   logic [3:0]  max_idx, min_idx;

   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   int   wr_err_cnt = 0;
   exp_t exp_q[$];

   mem_stats_engine dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .busy(busy), .done(done), .wr_err(wr_err), .sum(sum),
      .max_val(max_val), .max_idx(max_idx), .min_val(min_val), .min_idx(min_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compare every done pulse against the oldest expected result.
   always @(negedge clk) begin
      if (wr_err === 1'b1) wr_err_cnt++;
      if (done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sum", 32'(sum), 32'(e.sum));
            chk("max_val", 32'(max_val), 32'(e.maxv));
            chk("max_idx", 32'(max_idx), 32'(e.maxi));
            chk("min_val", 32'(min_val), 32'(e.minv));
            chk("min_idx", 32'(min_idx), 32'(e.mini));
         end
      end
   end

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Pulses start (any wr_en already set rides along), optionally contends mid-scan.
   task automatic run_scan(input exp_t e, input int contend_at);
      int busy_cnt;
      int done_k;
      exp_q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      busy_cnt = 0; done_k = -1;
      for (int k = 0; k < 40; k++) begin
         if (k == contend_at) begin
            start = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'd99;
         end else begin
            start = 1'b0; wr_en = 1'b0;
         end
         if (done === 1'b1) begin
            done_k = k;
            break;
         end
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
      end
      start = 1'b0; wr_en = 1'b0;
      chk("busy_cycles", 32'(busy_cnt), 32'd14);
      chk("done_latency", 32'(done_k), 32'd14);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   function automatic logic [7:0] tie_val(input int i);
      if (i == 3 || i == 9) return 8'd200;
      else if (i == 5 || i == 12) return 8'd2;
      else return 8'd50;
   endfunction

   initial begin
      int d0, w0;
      exp_t ramp_e, sat_e, tie_e, zero_e;
      ramp_e = '{sum: 12'd105,  maxv: 8'd14,  maxi: 4'd13, minv: 8'd1,   mini: 4'd0};
      sat_e  = '{sum: 12'd3570, maxv: 8'd255, maxi: 4'd0,  minv: 8'd255, mini: 4'd0};
      tie_e  = '{sum: 12'd904,  maxv: 8'd200, maxi: 4'd3,  minv: 8'd2,   mini: 4'd5};
      zero_e = '{sum: 12'd0,    maxv: 8'd0,   maxi: 4'd0,  minv: 8'd0,   mini: 4'd0};

      rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_err", 32'(wr_err), 32'd0);
      chk("rst_outputs", 32'(sum) | 32'(max_val) | 32'(max_idx) | 32'(min_val) | 32'(min_idx), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) wr(4'(i), 8'(i + 1));
      run_scan(ramp_e, -1);

      for (int i = 0; i < 14; i++) wr(4'(i), 8'd255);
      run_scan(sat_e, -1);

      for (int i = 0; i < 14; i++) wr(4'(i), tie_val(i));
      run_scan(tie_e, -1);

      // Contention: restart attempt and write during busy.
      d0 = done_cnt; w0 = wr_err_cnt;
      run_scan(tie_e, 3);
      repeat (20) @(negedge clk);
      chk("contend_done_once", 32'(done_cnt - d0), 32'd1);
      chk("contend_wr_err", 32'(wr_err_cnt - w0), 32'd1);

      // Out-of-range write in IDLE.
      w0 = wr_err_cnt;
      wr(4'd14, 8'd0);
      @(negedge clk);
      chk("oob_wr_err", 32'(wr_err_cnt - w0), 32'd1);
      run_scan(tie_e, -1);

      // Reset in the sixth scan cycle.
      for (int i = 0; i < 14; i++) wr(4'(i), 8'(i + 1));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_outputs", 32'(sum) | 32'(max_val) | 32'(max_idx) | 32'(min_val) | 32'(min_idx), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

      run_scan(zero_e, -1);

      // Ramp again with the last write in the same cycle as start.
      for (int i = 0; i < 13; i++) wr(4'(i), 8'(i + 1));
      wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'd14;
      run_scan(ramp_e, -1);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
